// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller.
//   state_t      : controller FSM states
//   OP_*         : opcode encodings understood by the external ALU
//   cmd_*        : layout of one queued command word {a, b, op, chain}
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_OXA = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  // Command word, LSB first: chain (1 bit), op (opw bits), b (width bits), a (width bits).
  localparam int CMD_CHAIN_BIT = 0;
  localparam int CMD_OP_LSB    = 1;

  function automatic int cmd_width(input int width, input int opw);
    return 2 * width + opw + 1;
  endfunction

  function automatic int cmd_b_lsb(input int opw);
    return CMD_OP_LSB + opw;
  endfunction

  function automatic int cmd_a_lsb(input int width, input int opw);
    return CMD_OP_LSB + opw + width;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of W bits, first-word fall-through
// read port (rdata always shows the head entry).
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, wdata  : write request/data; ignored while full
//   pop          : remove head entry; ignored while empty
//   rdata        : head entry (undefined while empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries (0..DEPTH)
module alu_cmd_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A refused push is decided on "full" alone, so a pop in the same cycle
  // never makes room for a push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array is deliberately not reset; pointers and count
  // alone define which entries are valid, and a reset RAM costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_seq_controller.sv
// Sequencing controller for an external combinational or pipelined ALU.
// Commands are queued, issued one at a time to registered ALU operand
// outputs, and the ALU result is captured ALU_LAT cycles after issue and
// held with done=1 until the consumer acknowledges it.
//   clk, reset           : clock, asynchronous active-low reset
//   start, a, b, op,
//   chain, ready         : command input; accepted on start && ready
//   alu_in1/in2/op       : registered operands/opcode to the ALU
//   alu_out, alu_flag    : ALU result and flag
//   result, flag, done,
//   res_ack              : result handshake; done held until res_ack
//   busy, count          : activity indicator and queue occupancy
module alu_seq_controller
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int OPW     = 2,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [OPW-1:0]             op,
  input  logic                       chain,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       alu_flag,
  output logic [WIDTH-1:0]           alu_in1,
  output logic [WIDTH-1:0]           alu_in2,
  output logic [OPW-1:0]             alu_op,
  output logic [WIDTH-1:0]           result,
  output logic                       flag,
  output logic                       done,
  input  logic                       res_ack,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CMD_W  = cmd_width(WIDTH, OPW);
  localparam int A_LSB  = cmd_a_lsb(WIDTH, OPW);
  localparam int B_LSB  = cmd_b_lsb(OPW);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LAT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LAT - 1);

  state_t            state;
  logic [LAT_W-1:0]  wait_cnt;
  logic [WIDTH-1:0]  acc;

  logic [CMD_W-1:0]  cmd_in;
  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              issue;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;
  logic [OPW-1:0]    head_op;
  logic              head_chain;
  logic [WIDTH-1:0]  issue_in1;

  assign cmd_in = {a, b, op, chain};

  alu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH),
    .CW    (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (start),
    .wdata (cmd_in),
    .pop   (issue),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign head_a     = head[A_LSB +: WIDTH];
  assign head_b     = head[B_LSB +: WIDTH];
  assign head_op    = head[CMD_OP_LSB +: OPW];
  assign head_chain = head[CMD_CHAIN_BIT];

  // A command leaves the queue either from IDLE, or straight out of HOLD on
  // the acknowledging edge so back-to-back commands lose no cycle.
  assign issue     = !fifo_empty && ((state == IDLE) || ((state == HOLD) && res_ack));
  // Chained commands take the last captured result; acc is already updated
  // by the time a chained command can issue from HOLD.
  assign issue_in1 = head_chain ? acc : head_a;

  assign ready = !fifo_full;
  assign busy  = (state != IDLE) || !fifo_empty;

  // NOTE: every register here is assigned with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_op   <= '0;
      result   <= '0;
      flag     <= 1'b0;
      done     <= 1'b0;
      acc      <= '0;
    end else begin
      // Operand registers only change on issue, so they stay stable through
      // WAIT/HOLD and keep their last values while idle.
      if (issue) begin
        alu_in1  <= issue_in1;
        alu_in2  <= head_b;
        alu_op   <= head_op;
        wait_cnt <= LAT_LOAD;
      end

      unique case (state)
        IDLE: begin
          if (issue) state <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            result <= alu_out;
            flag   <= alu_flag;
            acc    <= alu_out;
            done   <= 1'b1;
            state  <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (res_ack) begin
            done  <= 1'b0;
            state <= issue ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_controller.sv
// Self-checking bench for alu_seq_controller: a single-cycle-latency
// instance with a scoreboard monitor, and a three-cycle-latency instance
// driven by a pipelined ALU model for the latency corner cases.
module tb_alu_seq_controller;
  import alu_ctrl_pkg::*;

  localparam int WIDTH = 6;
  localparam int OPW   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
    logic             chain;
    logic [WIDTH-1:0] exp_in1;
    logic [WIDTH-1:0] exp_res;
    logic             exp_flag;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] res;
    logic             flag;
  } sb_t;

  // ALU reference: flag is "result non-zero".
  function automatic logic [WIDTH:0] alu_f(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic [OPW-1:0]   o);
    logic [WIDTH-1:0] r;
    case (o)
      OP_ADD:  r = x + y;
      OP_OXA:  r = x ^ y;
      OP_SUB:  r = x - y;
      default: r = x & y;
    endcase
    return {|r, r};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;

  // Instance with ALU_LAT=1 and a combinational ALU model.
  logic             start, chain, res_ack, ready, done, busy, flag, alu_flag;
  logic [WIDTH-1:0] a, b, alu_out, alu_in1, alu_in2, result;
  logic [OPW-1:0]   op, alu_op;
  logic [CW-1:0]    count;

  assign {alu_flag, alu_out} = alu_f(alu_in1, alu_in2, alu_op);

  alu_seq_controller #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .a(a), .b(b), .op(op),
    .chain(chain), .alu_out(alu_out), .alu_flag(alu_flag), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_op(alu_op), .result(result), .flag(flag), .done(done),
    .res_ack(res_ack), .busy(busy), .count(count)
  );

  // Instance with ALU_LAT=3 and a two-register ALU pipeline: alu_out3 only
  // reflects the current operands from the cycle before the capture edge.
  logic             start3, chain3, ack3, ready3, done3, busy3, flag3, aluf3;
  logic [WIDTH-1:0] a3, b3, aluo3, in1_3, in2_3, result3;
  logic [OPW-1:0]   op3, op_3;
  logic [CW-1:0]    count3;
  logic [WIDTH:0]   p1 = '0;
  logic [WIDTH:0]   p2 = '0;

  always @(posedge clk) begin
    p1 <= alu_f(in1_3, in2_3, op_3);
    p2 <= p1;
  end
  assign {aluf3, aluo3} = p2;

  alu_seq_controller #(.WIDTH(WIDTH), .OPW(OPW), .DEPTH(DEPTH), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ready(ready3), .a(a3), .b(b3), .op(op3),
    .chain(chain3), .alu_out(aluo3), .alu_flag(aluf3), .alu_in1(in1_3),
    .alu_in2(in2_3), .alu_op(op_3), .result(result3), .flag(flag3), .done(done3),
    .res_ack(ack3), .busy(busy3), .count(count3)
  );

  int checks   = 0;
  int failures = 0;
  int sb_pops  = 0;
  sb_t sb[$];
  logic [WIDTH-1:0] model_acc = '0;

  logic [WIDTH-1:0] t6a [3] = '{6'd1, 6'd2, 6'd63};
  logic [WIDTH-1:0] t6b [3] = '{6'd1, 6'd2, 6'd1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted commands (with the bench's own accumulator)
  // and compare each result as it is acknowledged.
  task automatic monitor();
    sb_t e;
    logic [WIDTH:0] r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        sb.delete();
        model_acc = '0;
      end else begin
        if (done && res_ack) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_result", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("sb_result", result, e.res);
            check("sb_flag", flag, e.flag);
            check("sb_alu_in1", alu_in1, e.in1);
            check("sb_alu_in2", alu_in2, e.in2);
            check("sb_alu_op", alu_op, e.op);
            sb_pops++;
          end
        end
        if (start && ready) begin
          e.in1 = chain ? model_acc : a;
          e.in2 = b;
          e.op  = op;
          r     = alu_f(e.in1, e.in2, e.op);
          e.res  = r[WIDTH-1:0];
          e.flag = r[WIDTH];
          model_acc = e.res;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic push_cmd(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                          input logic [OPW-1:0] iop, input logic ich);
    int n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("push_ready_timeout", 32'd0, 32'd1);
    a = ia; b = ib; op = iop; chain = ich; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check(name, 32'd0, 32'd1);
  endtask

  task automatic ack_one();
    res_ack = 1'b1;
    @(posedge clk); #1;
    res_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    int   n, pops0, nres, c0;
    int   rcyc [3];
    logic [WIDTH-1:0] rres [3];

    vecs[0] = '{a: 6'd9,  b: 6'd5,  op: OP_ADD, chain: 1'b1, exp_in1: 6'd0,  exp_res: 6'd5,  exp_flag: 1'b1};
    vecs[1] = '{a: 6'd10, b: 6'd7,  op: OP_OXA, chain: 1'b0, exp_in1: 6'd10, exp_res: 6'd13, exp_flag: 1'b1};
    vecs[2] = '{a: 6'd0,  b: 6'd2,  op: OP_ADD, chain: 1'b1, exp_in1: 6'd13, exp_res: 6'd15, exp_flag: 1'b1};
    vecs[3] = '{a: 6'd3,  b: 6'd5,  op: OP_SUB, chain: 1'b1, exp_in1: 6'd15, exp_res: 6'd10, exp_flag: 1'b1};
    vecs[4] = '{a: 6'd0,  b: 6'd10, op: OP_SUB, chain: 1'b1, exp_in1: 6'd10, exp_res: 6'd0,  exp_flag: 1'b0};
    vecs[5] = '{a: 6'd5,  b: 6'd6,  op: OP_SUB, chain: 1'b0, exp_in1: 6'd5,  exp_res: 6'd63, exp_flag: 1'b1};
    vecs[6] = '{a: 6'd42, b: 6'd27, op: OP_AND, chain: 1'b0, exp_in1: 6'd42, exp_res: 6'd10, exp_flag: 1'b1};
    vecs[7] = '{a: 6'd63, b: 6'd63, op: OP_ADD, chain: 1'b0, exp_in1: 6'd63, exp_res: 6'd62, exp_flag: 1'b1};

    start = 1'b0; a = '0; b = '0; op = '0; chain = 1'b0; res_ack = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; op3 = '0; chain3 = 1'b0; ack3 = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    fork
      monitor();
    join_none

    // Reset state.
    check("rst_ready", ready, 1);
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flag", flag, 0);
    check("rst_alu_regs", {alu_in1, alu_in2, alu_op}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single add: operands one edge after acceptance, result one edge later.
    push_cmd(6'd5, 6'd3, OP_ADD, 1'b0);
    @(posedge clk); #1;
    check("add_alu_in1", alu_in1, 5);
    check("add_alu_in2", alu_in2, 3);
    check("add_alu_op", alu_op, OP_ADD);
    check("add_done_early", done, 0);
    @(posedge clk); #1;
    check("add_done", done, 1);
    check("add_result", result, 8);
    check("add_flag", flag, 1);
    repeat (2) begin
      @(posedge clk); #1;
      check("add_done_held", {done, result}, {1'b1, 6'd8});
    end
    ack_one();
    check("add_done_cleared", done, 0);
    check("add_idle", busy, 0);

    // Reset while both instances are in WAIT with work still queued.
    a = 6'd11; b = 6'd4; op = OP_ADD; chain = 1'b0; start = 1'b1;
    a3 = 6'd11; b3 = 6'd4; op3 = OP_ADD; chain3 = 1'b0; start3 = 1'b1;
    @(posedge clk); #1;
    a = 6'd12; start3 = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("midwait_count", count, 1);
    check("midwait_busy3", busy3, 1);
    reset = 1'b0;
    #1;
    check("async_rst_done", {done, done3}, 0);
    check("async_rst_count", {count, count3}, 0);
    check("async_rst_alu_in1", {alu_in1, in1_3}, 0);
    check("async_rst_busy", {busy, busy3}, 0);
    check("async_rst_ready", {ready, ready3}, 2'b11);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_done_after_reset", {done, done3, busy, busy3}, 0);
    end

    // Table of single commands; chain rows depend on the previous row.
    for (int i = 0; i < 8; i++) begin
      push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].chain);
      wait_done($sformatf("vec%0d_timeout", i));
      check($sformatf("vec%0d_alu_in1", i), alu_in1, vecs[i].exp_in1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d_flag", i), flag, vecs[i].exp_flag);
      ack_one();
    end

    // Queue full: no acks, five pushes leave four queued and one in HOLD.
    for (int i = 0; i < 5; i++) begin
      push_cmd(6'(i * 3 + 1), 6'(i + 2), 2'(i), 1'b0);
      check("full_count_bound", count > CW'(DEPTH), 0);
    end
    check("full_ready", ready, 0);
    check("full_count", count, 4);
    a = 6'd33; b = 6'd33; op = OP_ADD; chain = 1'b0; start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("full_refused", {ready, count}, {1'b0, CW'(4)});
    end
    start = 1'b0;
    pops0 = sb_pops;
    res_ack = 1'b1;
    n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    res_ack = 1'b0;
    check("full_drain_timeout", busy || done, 0);
    check("full_results_seen", sb_pops - pops0, 5);
    check("full_sb_empty", sb.size(), 0);

    // Back-to-back with res_ack held high.
    res_ack = 1'b1;
    nres = 0;
    c0 = cyc;
    for (int k = 0; k < 30; k++) begin
      if (k < 3) begin
        a = t6a[k]; b = t6b[k]; op = OP_ADD; chain = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done && nres < 3) begin
        rcyc[nres] = cyc;
        rres[nres] = result;
        nres++;
      end
    end
    res_ack = 1'b0;
    check("b2b_count", nres, 3);
    check("b2b_first_latency", rcyc[0] - c0, 3);
    check("b2b_res0", rres[0], 2);
    check("b2b_res1", rres[1], 4);
    check("b2b_res2_wrap", rres[2], 0);
    check("b2b_spacing01", rcyc[1] - rcyc[0], 2);
    check("b2b_spacing12", rcyc[2] - rcyc[1], 2);

    // Latency 3: first command leaves 21 in the ALU pipeline, the second
    // must capture 16, never the stale 21.
    a3 = 6'd20; b3 = 6'd1; op3 = OP_ADD; chain3 = 1'b0; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("lat3_first_result", {done3, result3}, {1'b1, 6'd21});
    ack3 = 1'b1;
    @(posedge clk); #1;
    ack3 = 1'b0;
    a3 = 6'd7; b3 = 6'd9; op3 = OP_ADD; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    @(posedge clk); #1;
    check("lat3_issue", {in1_3, in2_3, op_3}, {6'd7, 6'd9, OP_ADD});
    check("lat3_issue_done", done3, 0);
    check("lat3_issue_queue", count3, 0);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check($sformatf("lat3_wait%0d_done", j), done3, 0);
      check($sformatf("lat3_wait%0d_stable", j), {in1_3, in2_3}, {6'd7, 6'd9});
    end
    @(posedge clk); #1;
    check("lat3_done", done3, 1);
    check("lat3_result", result3, 16);
    check("lat3_flag", flag3, 1);
    ack3 = 1'b1;
    @(posedge clk); #1;
    ack3 = 1'b0;
    check("lat3_idle", {done3, busy3, ready3}, 3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
